mmss_timer: RTL and testbench
=============================

Name: mmss_timer

Overview:
- Parametrised MM:SS BCD timer, the successor to the fixed 60:00 countdown display counter.
- Adds an internal tick divider with exact period, preset load with validation, up/down mode, start/pause control, and terminal-count flags.
- Drives the 4-digit seven-segment display path and the control FSM in the top-level lab designs.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per count step (>=2).
- MIN_MAX, 60, maximum minutes value (1..99); terminal/limit value is MIN_MAX:00.
- DIV_W, $clog2(TICK_DIV), divider counter width (derived, not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- load  in  1  pulse; load load_val as new preset and value
- load_val  in  16  BCD {min_tens,min_ones,sec_tens,sec_ones}
- start  in  1  pulse; start or resume
- pause  in  1  pulse; suspend counting
- up_dn  in  1  1=count up, 0=count down; sampled on accepted start
- digits  out  16  current BCD value, same packing as load_val
- tick  out  1  one-cycle pulse on each count step
- running  out  1  high in RUN
- done  out  1  high in DONE
- expired  out  1  one-cycle pulse on reaching terminal value
- load_err  out  1  one-cycle pulse when load_val is rejected

Behaviour:
- Reset values:
  - digits = MIN_MAX:00 in BCD; preset register = MIN_MAX:00.
  - Mode = down; state IDLE; divider = 0; all pulse and level outputs 0.
- FSM states: IDLE, RUN, PAUSE, DONE.
- Input priority: rst > load > pause > start > tick.
- Load validity: every digit <=9; sec_tens <=5; minutes < MIN_MAX, or minutes == MIN_MAX with seconds == 00.
  - Valid load in any state: digits and preset <= load_val, divider <= 0, state -> IDLE.
  - Invalid load: state and digits unchanged, load_err pulses the next cycle.
- start in IDLE or PAUSE:
  - Latches up_dn and goes to RUN.
  - From IDLE the divider is cleared, so the first tick comes exactly TICK_DIV cycles after the start edge.
  - From PAUSE the divider value is kept, so the fractional second is preserved.
  - If digits already equal the terminal value for the latched mode, go to DONE next cycle and pulse expired.
- start in RUN or DONE: ignored.
- pause in RUN: -> PAUSE, divider frozen. pause elsewhere: ignored.
- Divider (RUN only):
  - Counts 0..TICK_DIV-1.
  - Reaching TICK_DIV-1 wraps it to 0 and asserts tick for that cycle.
  - Period is exactly TICK_DIV cycles.
- Down step:
  - sec_ones decrements; 0 borrows to 9.
  - sec_tens 0 borrows to 5.
  - min_ones 0 borrows to 9.
  - min_tens decrements.
- Up step:
  - sec_ones 9 -> 0 and carries.
  - sec_tens 5 -> 0 and carries.
  - min_ones 9 -> 0 and carries.
  - min_tens increments.
- Terminal value: 00:00 when counting down; MIN_MAX:00 when counting up.
  - The step that lands on it updates digits, pulses expired in the same cycle, and goes to DONE.
  - DONE holds digits; done=1 until the next valid load or rst.
- Simultaneous events:
  - load with tick: the load wins and no step is taken.
  - pause with tick in the same cycle: the pause wins and the step is discarded.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).
- Outputs are registered: digits, tick and expired change on the same edge; running and done follow the state register.

Optional Feature:
- Macro: TIMER_AUTORELOAD_EN.
- Defined: reaching the terminal value while counting down reloads digits from the preset in the same cycle.
  - expired pulses; state stays RUN; done never asserts in down mode.
  - Up mode is unchanged and still goes to DONE.
- Undefined: terminal value always enters DONE as described above.

Decomposition:
- Package timer_pkg holds:
  - state enum timer_state_t (IDLE/RUN/PAUSE/DONE);
  - typedef bcd_t (4-bit);
  - mmss_t struct of four bcd_t;
  - constants MODE_UP=1, MODE_DN=0;
  - pure functions mmss_inc, mmss_dec and mmss_valid.
- One sub-module, tick_div: divider with clear, hold and tick output.
- FSM and digit registers stay in mmss_timer.

Test Plan (TICK_DIV=4, MIN_MAX=60 unless noted):
- Reset, then start (down) -> digits 60:00; first tick 4 cycles after start; digits 59:59; tick period exactly 4 cycles thereafter.
- load 00:02, start down -> 00:01, then 00:00 with expired pulse; done=1; digits hold 00:00 for 20 further cycles.
- load 09:59, start up -> next tick gives 10:00 (three-level carry). load 59:59, start up -> 60:00 with expired pulse, done=1.
- load 00:75 -> load_err pulses, digits unchanged. load 60:01 -> rejected. load 60:00 -> accepted.
- Running, pause 2 cycles into a period, wait 10 cycles, start -> next tick after the remaining 2 cycles; pause and tick in the same cycle -> no step.
- With TIMER_AUTORELOAD_EN defined: load 00:01, start down -> 00:00 with expired pulse in the same cycle digits return to 00:01; running stays 1.

Source files
------------

// File: rtl/mmss_timer_pkg.sv
// Shared types and BCD step/validation helpers for the MM:SS timer.
// Optional feature macro used by the top level: TIMER_AUTORELOAD_EN.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    typedef logic [3:0] bcd_t;

    // Packed so that minTens lands in bits [15:12], matching the port packing.
    typedef struct packed {
        bcd_t minTens;
        bcd_t minOnes;
        bcd_t secTens;
        bcd_t secOnes;
    } mmss_t;

    localparam logic MODE_UP = 1'b1;
    localparam logic MODE_DN = 1'b0;

    function automatic mmss_t mmss_inc(input mmss_t v);
        mmss_t r;
        r = v;
        if (v.secOnes != 4'd9) begin
            r.secOnes = v.secOnes + 4'd1;
        end else begin
            r.secOnes = 4'd0;
            if (v.secTens != 4'd5) begin
                r.secTens = v.secTens + 4'd1;
            end else begin
                r.secTens = 4'd0;
                if (v.minOnes != 4'd9) begin
                    r.minOnes = v.minOnes + 4'd1;
                end else begin
                    r.minOnes = 4'd0;
                    r.minTens = v.minTens + 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic mmss_t mmss_dec(input mmss_t v);
        mmss_t r;
        r = v;
        if (v.secOnes != 4'd0) begin
            r.secOnes = v.secOnes - 4'd1;
        end else begin
            r.secOnes = 4'd9;
            if (v.secTens != 4'd0) begin
                r.secTens = v.secTens - 4'd1;
            end else begin
                r.secTens = 4'd5;
                if (v.minOnes != 4'd0) begin
                    r.minOnes = v.minOnes - 4'd1;
                end else begin
                    r.minOnes = 4'd9;
                    r.minTens = v.minTens - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // The limit value itself (maxMin:00) is legal; anything past it is not.
    function automatic logic mmss_valid(input mmss_t v, input int maxMin);
        int   minutes;
        logic digitsOk;
        logic secZero;
        minutes  = int'(v.minTens) * 10 + int'(v.minOnes);
        digitsOk = (v.minTens <= 4'd9) && (v.minOnes <= 4'd9) &&
                   (v.secTens <= 4'd5) && (v.secOnes <= 4'd9);
        secZero  = (v.secTens == 4'd0) && (v.secOnes == 4'd0);
        return digitsOk && ((minutes < maxMin) || ((minutes == maxMin) && secZero));
    endfunction

endpackage

// File: rtl/mmss_timer_tick_div.sv
// Count-step divider: wraps every TICK_DIV enabled cycles, with clear and hold.
module tick_div #(
    parameter int TICK_DIV = 4,
    parameter int DIV_W    = $clog2(TICK_DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            if (r_count == LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + DIV_W'(1);
            end
        end
    end

    // Flags the wrap point; the owner decides whether this cycle really steps.
    assign o_tick = (r_count == LAST);

endmodule

// File: rtl/mmss_timer.sv
// MM:SS BCD up/down timer with preset load, start/pause and terminal flags.
// Optional feature macro: TIMER_AUTORELOAD_EN (down-count reloads from preset).
module mmss_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int MIN_MAX  = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        start,
    input  logic        pause,
    input  logic        up_dn,
    output logic [15:0] digits,
    output logic        tick,
    output logic        running,
    output logic        done,
    output logic        expired,
    output logic        load_err
);

    localparam int DIV_W = $clog2(TICK_DIV);

    localparam mmss_t MAX_VAL = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10), 8'h00};

`ifdef TIMER_AUTORELOAD_EN
    localparam logic AUTO_RELOAD = 1'b1;
`else
    localparam logic AUTO_RELOAD = 1'b0;
`endif

    function automatic mmss_t termFor(input logic mode);
        return (mode == MODE_UP) ? MAX_VAL : mmss_t'(16'h0000);
    endfunction

    timer_state_t r_state;
    timer_state_t w_stateNext;
    mmss_t        r_digits;
    mmss_t        w_digitsNext;
    mmss_t        r_preset;
    mmss_t        w_presetNext;
    mmss_t        w_loadVal;
    mmss_t        w_stepped;
    logic         r_mode;
    logic         w_modeNext;
    logic         r_tick;
    logic         w_tickNext;
    logic         r_expired;
    logic         w_expiredNext;
    logic         r_loadErr;
    logic         w_loadErrNext;
    logic         w_loadOk;
    logic         w_divClear;
    logic         w_divEn;
    logic         w_divWrap;

    assign w_loadVal = mmss_t'(load_val);
    assign w_loadOk  = mmss_valid(w_loadVal, MIN_MAX);
    assign w_stepped = (r_mode == MODE_UP) ? mmss_inc(r_digits) : mmss_dec(r_digits);

    tick_div #(
        .TICK_DIV(TICK_DIV),
        .DIV_W   (DIV_W)
    ) u_tickDiv (
        .clk    (clk),
        .rst    (rst),
        .i_clear(w_divClear),
        .i_en   (w_divEn),
        .o_tick (w_divWrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Branch order encodes the priority load > pause > start > tick.
    always_comb begin
        w_stateNext   = r_state;
        w_digitsNext  = r_digits;
        w_presetNext  = r_preset;
        w_modeNext    = r_mode;
        w_tickNext    = 1'b0;
        w_expiredNext = 1'b0;
        w_loadErrNext = 1'b0;
        w_divClear    = 1'b0;
        w_divEn       = 1'b0;

        if (load) begin
            if (w_loadOk) begin
                w_digitsNext = w_loadVal;
                w_presetNext = w_loadVal;
                w_divClear   = 1'b1;
                w_stateNext  = IDLE;
            end else begin
                w_loadErrNext = 1'b1;
            end
        end else if (pause && (r_state == RUN)) begin
            w_stateNext = PAUSE;
        end else if (start && ((r_state == IDLE) || (r_state == PAUSE))) begin
            w_modeNext = up_dn;
            w_divClear = (r_state == IDLE);
            if (r_digits == termFor(up_dn)) begin
                w_expiredNext = 1'b1;
                if (AUTO_RELOAD && (up_dn == MODE_DN)) begin
                    w_digitsNext = r_preset;
                    w_stateNext  = RUN;
                end else begin
                    w_stateNext = DONE;
                end
            end else begin
                w_stateNext = RUN;
            end
        end else if (r_state == RUN) begin
            w_divEn = 1'b1;
            if (w_divWrap) begin
                w_tickNext = 1'b1;
                if (w_stepped == termFor(r_mode)) begin
                    w_expiredNext = 1'b1;
                    if (AUTO_RELOAD && (r_mode == MODE_DN)) begin
                        w_digitsNext = r_preset;
                    end else begin
                        w_digitsNext = w_stepped;
                        w_stateNext  = DONE;
                    end
                end else begin
                    w_digitsNext = w_stepped;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits  <= MAX_VAL;
            r_preset  <= MAX_VAL;
            r_mode    <= MODE_DN;
            r_tick    <= 1'b0;
            r_expired <= 1'b0;
            r_loadErr <= 1'b0;
        end else begin
            r_digits  <= w_digitsNext;
            r_preset  <= w_presetNext;
            r_mode    <= w_modeNext;
            r_tick    <= w_tickNext;
            r_expired <= w_expiredNext;
            r_loadErr <= w_loadErrNext;
        end
    end

    assign digits   = r_digits;
    assign tick     = r_tick;
    assign expired  = r_expired;
    assign load_err = r_loadErr;
    assign running  = (r_state == RUN);
    assign done     = (r_state == DONE);

endmodule

// File: tb/tb_mmss_timer.sv
// Self-checking bench for mmss_timer: seconds-level reference model plus directed checks.
// Adds an auto-reload scenario when TIMER_AUTORELOAD_EN is defined.
module tb_mmss_timer;

    localparam int TICK_DIV = 4;
    localparam int MIN_MAX  = 60;
    localparam int TERM_UP  = MIN_MAX * 60;
    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_PAUSE  = 2;
    localparam int S_DONE   = 3;

`ifdef TIMER_AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        up_dn = 1'b0;
    logic [15:0] digits;
    logic        tick;
    logic        running;
    logic        done;
    logic        expired;
    logic        load_err;

    int compared   = 0;
    int mismatched = 0;

    mmss_timer #(
        .TICK_DIV(TICK_DIV),
        .MIN_MAX (MIN_MAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .load_val(load_val),
        .start   (start),
        .pause   (pause),
        .up_dn   (up_dn),
        .digits  (digits),
        .tick    (tick),
        .running (running),
        .done    (done),
        .expired (expired),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] toBcd(input int t);
        int m;
        int s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Reference model: time kept as a plain seconds count, steps every TICK_DIV run cycles.
    int mSecs;
    int mPreset;
    int mElapsed;
    int mState;
    bit mUp;
    bit eTick;
    bit eExp;
    bit eErr;

    always @(posedge clk or posedge rst) begin : model
        int s, pre, el, st, d3, d2, d1, d0, mins, secs, tgt;
        bit up, tk, ex, er, ok;
        if (rst) begin
            mSecs    <= TERM_UP;
            mPreset  <= TERM_UP;
            mElapsed <= 0;
            mState   <= S_IDLE;
            mUp      <= 1'b0;
            eTick    <= 1'b0;
            eExp     <= 1'b0;
            eErr     <= 1'b0;
        end else begin
            s = mSecs; pre = mPreset; el = mElapsed; st = mState; up = mUp;
            tk = 0; ex = 0; er = 0;
            if (load) begin
                d3 = int'(load_val[15:12]); d2 = int'(load_val[11:8]);
                d1 = int'(load_val[7:4]);   d0 = int'(load_val[3:0]);
                mins = d3 * 10 + d2;
                secs = d1 * 10 + d0;
                ok = (d3 <= 9) && (d2 <= 9) && (d1 <= 5) && (d0 <= 9) &&
                     ((mins < MIN_MAX) || ((mins == MIN_MAX) && (secs == 0)));
                if (ok) begin
                    s = mins * 60 + secs; pre = s; el = 0; st = S_IDLE;
                end else begin
                    er = 1;
                end
            end else if (pause && st == S_RUN) begin
                st = S_PAUSE;
            end else if (start && (st == S_IDLE || st == S_PAUSE)) begin
                up = up_dn;
                if (st == S_IDLE) el = 0;
                tgt = up ? TERM_UP : 0;
                if (s == tgt) begin
                    ex = 1;
                    if (AUTO && !up) begin s = pre; st = S_RUN; end
                    else st = S_DONE;
                end else begin
                    st = S_RUN;
                end
            end else if (st == S_RUN) begin
                el++;
                if (el == TICK_DIV) begin
                    el = 0; tk = 1;
                    s = up ? s + 1 : s - 1;
                    tgt = up ? TERM_UP : 0;
                    if (s == tgt) begin
                        ex = 1;
                        if (AUTO && !up) s = pre;
                        else st = S_DONE;
                    end
                end
            end
            mSecs <= s; mPreset <= pre; mElapsed <= el; mState <= st; mUp <= up;
            eTick <= tk; eExp <= ex; eErr <= er;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("model digits",   32'(digits),   32'(toBcd(mSecs)));
            checkOutput("model tick",     32'(tick),     32'(eTick));
            checkOutput("model running",  32'(running),  32'(mState == S_RUN));
            checkOutput("model done",     32'(done),     32'(mState == S_DONE));
            checkOutput("model expired",  32'(expired),  32'(eExp));
            checkOutput("model load_err", 32'(load_err), 32'(eErr));
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic l, input logic [15:0] lv, input logic s,
                                 input logic p, input logic ud);
        load = l; load_val = lv; start = s; pause = p; up_dn = ud;
        waitCycles(1);
        load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    task automatic waitTick(input string name, input int expN);
        int n;
        n = 0;
        do begin
            waitCycles(1);
            n++;
        end while (!tick && n < 20);
        checkOutput(name, 32'(n), 32'(expN));
    endtask

    initial begin
        #1 rst = 1'b1;
        waitCycles(2);
        #1 rst = 1'b0;
        waitCycles(1);
        $display("[TB] reset released");
        checkOutput("reset digits", 32'(digits), 32'h6000);
        checkOutput("reset running", 32'(running), 32'h0);

        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        checkOutput("start running", 32'(running), 32'h1);
        waitTick("first tick latency", 4);
        checkOutput("first step", 32'(digits), 32'h5959);
        waitTick("tick period", 4);
        checkOutput("second step", 32'(digits), 32'h5958);

        applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        checkOutput("load 00:02", 32'(digits), 32'h0002);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        waitTick("down tick 1", 4);
        checkOutput("down 00:01", 32'(digits), 32'h0001);
        waitTick("down tick 2", 4);
        checkOutput("down 00:00", 32'(digits), 32'h0000);
        checkOutput("down expired", 32'(expired), 32'h1);
        checkOutput("down done", 32'(done), 32'h1);
        waitCycles(20);
        checkOutput("done hold digits", 32'(digits), 32'h0000);
        checkOutput("done hold flag", 32'(done), 32'h1);

        applyStimulus(1'b1, 16'h0959, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        waitTick("up tick carry", 4);
        checkOutput("carry 10:00", 32'(digits), 32'h1000);
        applyStimulus(1'b1, 16'h5959, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        waitTick("up tick limit", 4);
        checkOutput("up 60:00", 32'(digits), 32'h6000);
        checkOutput("up expired", 32'(expired), 32'h1);
        checkOutput("up done", 32'(done), 32'h1);

        applyStimulus(1'b1, 16'h0075, 1'b0, 1'b0, 1'b0);
        checkOutput("reject 00:75 err", 32'(load_err), 32'h1);
        checkOutput("reject 00:75 digits", 32'(digits), 32'h6000);
        checkOutput("reject keeps done", 32'(done), 32'h1);
        applyStimulus(1'b1, 16'h6001, 1'b0, 1'b0, 1'b0);
        checkOutput("reject 60:01 err", 32'(load_err), 32'h1);
        applyStimulus(1'b1, 16'h6000, 1'b0, 1'b0, 1'b0);
        checkOutput("accept 60:00 err", 32'(load_err), 32'h0);
        checkOutput("accept 60:00 done", 32'(done), 32'h0);

        applyStimulus(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        waitCycles(2);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        checkOutput("paused running", 32'(running), 32'h0);
        waitCycles(10);
        checkOutput("paused digits", 32'(digits), 32'h1000);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        waitTick("resume remainder", 2);
        checkOutput("resume step", 32'(digits), 32'h0959);
        waitCycles(3);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        checkOutput("pause beats tick", 32'(tick), 32'h0);
        checkOutput("pause no step", 32'(digits), 32'h0959);
        waitCycles(5);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        waitTick("resume at wrap", 1);
        checkOutput("late step", 32'(digits), 32'h0958);

        waitCycles(1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset digits", 32'(digits), 32'h6000);
        checkOutput("async reset running", 32'(running), 32'h0);
        #1 rst = 1'b0;
        waitCycles(1);

        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        checkOutput("start at limit done", 32'(done), 32'h1);
        checkOutput("start at limit expired", 32'(expired), 32'h1);

`ifdef TIMER_AUTORELOAD_EN
        applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        waitTick("reload tick", 4);
        checkOutput("reload digits", 32'(digits), 32'h0001);
        checkOutput("reload expired", 32'(expired), 32'h1);
        checkOutput("reload running", 32'(running), 32'h1);
        waitCycles(6);
`endif

        waitCycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
